// File: rtl/rf_arb_pkg.sv
// Shared arbiter types: FSM states, read-return tag and port-select helpers.
// Tags are sized for the largest port count, so one tag type works in every build.
package rf_arb_pkg;
  localparam int MAX_PORTS = 8;
  localparam int PORT_ID_W = $clog2(MAX_PORTS);

  typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} arb_state_t;

  typedef struct packed {
    logic                 vld;
    logic [PORT_ID_W-1:0] id;
  } rd_tag_t;

  // Returns the first requester at or after ptr, wrapping within the n live ports.
  function automatic logic [MAX_PORTS-1:0] rr_pick(input logic [MAX_PORTS-1:0] req,
                                                   input logic [PORT_ID_W-1:0] ptr,
                                                   input int unsigned          n);
    logic [MAX_PORTS-1:0] oh;
    logic                 found;
    int unsigned          idx;
    oh    = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_PORTS; k++) begin
      idx = (32'(ptr) + k) % n;
      if (k < n && !found && req[idx[PORT_ID_W-1:0]]) begin
        oh[idx[PORT_ID_W-1:0]] = 1'b1;
        found                  = 1'b1;
      end
    end
    return oh;
  endfunction

  function automatic logic [PORT_ID_W-1:0] oh2idx(input logic [MAX_PORTS-1:0] oh);
    logic [PORT_ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (oh[i]) idx = PORT_ID_W'(i);
    end
    return idx;
  endfunction
endpackage

// File: rtl/rf_rd_tag_pipe.sv
// Delay line of {valid, port_id} tags aligned to the RAM read latency.
// Latency RD_LAT cycles; no backpressure, every pushed tag emerges exactly RD_LAT cycles later.
module rf_rd_tag_pipe
  import rf_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_push_vld,
  input  logic [PORT_ID_W-1:0] i_push_id,
  output logic                 o_pop_vld,
  output logic [PORT_ID_W-1:0] o_pop_id
);
  rd_tag_t r_tag [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= '{vld: i_push_vld, id: i_push_id};
      for (int i = 1; i < RD_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign o_pop_vld = r_tag[RD_LAT-1].vld;
  assign o_pop_id  = r_tag[RD_LAT-1].id;
endmodule

// File: rtl/rf_bram_arbiter.sv
// Arbitrates NUM_PORTS requesters onto one RF RAM port (RF_BRAM_ARB_FIXED_PRIO_EN: lowest index wins).
// Grant 1 cycle after req, one bubble per hand-over; requesters stall until gnt, reads return RD_LAT later.
module rf_bram_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 1408,
  parameter int RD_LAT    = 1,
  parameter int LOCK_MAX  = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        lock,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata,
  output logic [NUM_PORTS-1:0]        gnt,
  output logic [NUM_PORTS-1:0]        rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic                        ram_en,
  output logic                        ram_we,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic [DATA_W-1:0]           ram_wdata,
  input  logic [DATA_W-1:0]           ram_rdata
);
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_t           r_state;
  logic [NUM_PORTS-1:0] r_gnt;
  logic [CNT_W-1:0]     r_beat_cnt;
  logic [MAX_PORTS-1:0] w_pick;
  logic [PORT_ID_W-1:0] w_owner;
  logic [PORT_ID_W-1:0] w_ptr;
  logic [PORT_ID_W-1:0] w_pop_id;
  logic                 w_beat;
  logic                 w_release;
  logic                 w_pop_vld;

`ifndef RF_BRAM_ARB_FIXED_PRIO_EN
  logic [PORT_ID_W-1:0] r_rr_ptr;
  assign w_ptr = r_rr_ptr;
`else
  assign w_ptr = '0;
`endif

  assign w_pick  = rr_pick(MAX_PORTS'(req), w_ptr, NUM_PORTS);
  assign w_owner = oh2idx(MAX_PORTS'(r_gnt));
  assign w_beat  = |(req & r_gnt);

  // Saturated count still forces release, so a late-arriving requester is never starved.
  assign w_release = (r_state == OWNED) &&
                     (!w_beat || !(|(lock & r_gnt)) ||
                      ((r_beat_cnt >= CNT_W'(LOCK_MAX - 1)) && |(req & ~r_gnt)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_beat_cnt <= '0;
`ifndef RF_BRAM_ARB_FIXED_PRIO_EN
      r_rr_ptr   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_gnt      <= NUM_PORTS'(w_pick);
            r_state    <= OWNED;
            r_beat_cnt <= '0;
          end
        end
        OWNED: begin
          if (w_release) begin
            r_gnt   <= '0;
            r_state <= IDLE;
`ifndef RF_BRAM_ARB_FIXED_PRIO_EN
            r_rr_ptr <= (w_owner == PORT_ID_W'(NUM_PORTS - 1)) ? '0 : w_owner + 1'b1;
`endif
          end else if (w_beat && (r_beat_cnt != CNT_W'(LOCK_MAX))) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign gnt    = r_gnt;
  assign ram_en = w_beat;
  assign ram_we = w_beat & |(we & r_gnt);

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (r_gnt[i] && w_beat) begin
        ram_addr  = addr[i*ADDR_W +: ADDR_W];
        ram_wdata = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  rf_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push_vld (w_beat & ~(|(we & r_gnt))),
    .i_push_id  (w_owner),
    .o_pop_vld  (w_pop_vld),
    .o_pop_id   (w_pop_id)
  );

  always_comb begin
    rvalid = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      rvalid[i] = w_pop_vld && (w_pop_id == PORT_ID_W'(i));
    end
  end

  assign rdata = ram_rdata;
endmodule

// File: tb/tb_rf_bram_arbiter.sv
// Bench for rf_bram_arbiter: transaction-level model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_rf_bram_arbiter;
  localparam int NP = 3;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int RL = 2;
  localparam int LM = 4;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic [NP-1:0]    req   = '0;
  logic [NP-1:0]    lock  = '0;
  logic [NP-1:0]    we    = '0;
  logic [NP*AW-1:0] addr  = '0;
  logic [NP*DW-1:0] wdata = '0;
  logic [NP-1:0]    gnt, rvalid;
  logic [DW-1:0]    rdata, ram_wdata, ram_rdata;
  logic             ram_en, ram_we;
  logic [AW-1:0]    ram_addr;

  int n_cmp = 0;
  int n_err = 0;

  int t2_g  [6] = '{1, 0, 2, 0, 1, 0};
  int t2_a  [6] = '{10, 0, 20, 0, 10, 0};
  int t3_g  [6] = '{1, 1, 1, 1, 0, 2};
  int t4_rv [5] = '{0, 0, 1, 0, 2};
`ifdef RF_BRAM_ARB_FIXED_PRIO_EN
  int t6_g  [5] = '{2, 0, 2, 0, 4};
`else
  int t6_g  [5] = '{2, 0, 4, 0, 4};
`endif

  rf_bram_arbiter #(
    .NUM_PORTS (NP), .ADDR_W (AW), .DATA_W (DW), .RD_LAT (RL), .LOCK_MAX (LM)
  ) dut (
    .clk (clk), .rst_n (rst_n), .req (req), .lock (lock), .we (we), .addr (addr),
    .wdata (wdata), .gnt (gnt), .rvalid (rvalid), .rdata (rdata), .ram_en (ram_en),
    .ram_we (ram_we), .ram_addr (ram_addr), .ram_wdata (ram_wdata), .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_word(input int a);
    return DW'(a * 257) ^ 16'h5A5A;
  endfunction

  // RAM model: sampled at negedge, committed at posedge, reads delayed RL cycles.
  logic [DW-1:0] mem   [1 << AW];
  logic [DW-1:0] rpipe [RL];
  logic          s_en, s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wd;
  assign ram_rdata = rpipe[RL-1];

  initial begin
    for (int a = 0; a < (1 << AW); a++) mem[a] = init_word(a);
    for (int i = 0; i < RL; i++) rpipe[i] = 16'hDEAD;
    s_en = 1'b0; s_we = 1'b0; s_addr = '0; s_wd = '0;
    forever begin
      @(negedge clk);
      s_en = ram_en; s_we = ram_we; s_addr = ram_addr; s_wd = ram_wdata;
      @(posedge clk);
      for (int i = RL - 1; i > 0; i--) rpipe[i] = rpipe[i-1];
      rpipe[0] = (s_en && !s_we) ? mem[s_addr] : 16'hDEAD;
      if (s_en && s_we) mem[s_addr] = s_wd;
    end
  end

  // Transaction model: who owns the port, beats in this grant, next-turn pointer, return schedule.
  int            m_owner = -1;
  int            m_beats = 0;
  int            m_ptr   = 0;
  int            m_cyc   = 0;
  logic [NP-1:0] exp_rv [4096];
  logic [DW-1:0] exp_rd [4096];

  function automatic int pick(input logic [NP-1:0] r, input int base);
    for (int k = 0; k < NP; k++) begin
      if (r[(base + k) % NP]) return (base + k) % NP;
    end
    return -1;
  endfunction

  initial begin
    logic beat, others;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_owner = -1; m_beats = 0; m_ptr = 0;
        foreach (exp_rv[i]) exp_rv[i] = '0;
      end else begin
        if (m_owner < 0) begin
`ifdef RF_BRAM_ARB_FIXED_PRIO_EN
          if (req != 0) begin m_owner = pick(req, 0); m_beats = 0; end
`else
          if (req != 0) begin m_owner = pick(req, m_ptr); m_beats = 0; end
`endif
        end else begin
          beat   = req[m_owner];
          others = (req & ~(NP'(1) << m_owner)) != 0;
          if (beat) begin
            m_beats++;
            if (!we[m_owner] && (m_cyc + RL < 4096)) begin
              exp_rv[m_cyc + RL] = NP'(1) << m_owner;
              exp_rd[m_cyc + RL] = mem[addr[m_owner*AW +: AW]];
            end
          end
          if (!beat || !lock[m_owner] || (m_beats >= LM && others)) begin
            m_ptr   = (m_owner + 1) % NP;
            m_owner = -1;
          end
        end
        m_cyc++;
      end
    end
  end

  initial begin
    logic [NP-1:0] eg, erv;
    logic          een, ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    forever begin
      @(negedge clk);
      eg = '0; een = 1'b0; ewe = 1'b0; ea = '0; ewd = '0;
      if (m_owner >= 0) begin
        eg  = NP'(1) << m_owner;
        een = req[m_owner];
        if (een) begin
          ewe = we[m_owner];
          ea  = addr[m_owner*AW +: AW];
          ewd = wdata[m_owner*DW +: DW];
        end
      end
      erv = exp_rv[m_cyc];
      chk("gnt", gnt, eg);
      chk("ram_en", ram_en, een);
      chk("ram_we", ram_we, ewe);
      chk("ram_addr", ram_addr, ea);
      chk("ram_wdata", ram_wdata, ewd);
      chk("rvalid", rvalid, erv);
      if (erv != 0) chk("rdata", rdata, exp_rd[m_cyc]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr[p*AW +: AW]  = a;
    wdata[p*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; lock = '0; we = '0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    // Single unlocked write from port 0.
    do_reset();
    set_port(0, 5, 16'h1234); req = 3'b001; we = 3'b001;
    #1;
    chk("t1_reset_gnt", gnt, 0); chk("t1_reset_rvalid", rvalid, 0); chk("t1_c0_ram_en", ram_en, 0);
    tick(); #1;
    chk("t1_c1_gnt", gnt, 1); chk("t1_c1_ram_en", ram_en, 1); chk("t1_c1_ram_we", ram_we, 1);
    chk("t1_c1_ram_addr", ram_addr, 5); chk("t1_c1_ram_wdata", ram_wdata, 16'h1234);
    tick(); req = '0; we = '0; #1;
    chk("t1_c2_gnt", gnt, 0);

    // Two-port contention with single beats.
    do_reset();
    set_port(0, 10, 16'hA0A0); set_port(1, 20, 16'hB1B1); req = 3'b011; we = 3'b011;
    for (int c = 0; c < 6; c++) begin
      tick(); #1;
      chk($sformatf("t2_gnt_c%0d", c + 1), gnt, t2_g[c]);
      chk($sformatf("t2_addr_c%0d", c + 1), ram_addr, t2_a[c]);
    end
    tick(); req = '0; we = '0; tick();

    // Locked burst is cut after LOCK_MAX beats when port 1 waits.
    do_reset();
    set_port(0, 30, 16'h3030); set_port(1, 40, 16'h4040);
    req = 3'b011; lock = 3'b001; we = 3'b011;
    for (int c = 0; c < 6; c++) begin
      tick(); #1;
      chk($sformatf("t3_gnt_c%0d", c + 1), gnt, t3_g[c]);
    end
    tick(); req = '0;
    tick(); req = 3'b001; lock = 3'b001; we = '0;
    for (int c = 0; c < 20; c++) begin
      tick(); #1;
      chk($sformatf("t3_solo_gnt_b%0d", c + 1), gnt, 1);
      chk($sformatf("t3_solo_en_b%0d", c + 1), ram_en, 1);
    end
    tick(); req = 3'b011; #1;
    chk("t3_late_gnt_owner", gnt, 1);
    tick(); #1;
    chk("t3_late_bubble", gnt, 0);
    tick(); #1;
    chk("t3_late_gnt_p1", gnt, 2);
    req = '0; lock = '0;
    tick(); tick(); tick();

    // Read returns routed by port across a hand-over.
    do_reset();
    set_port(0, 3, 16'h0000); set_port(1, 7, 16'h0000); req = 3'b011;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 4) req = '0;
      #1;
      chk($sformatf("t4_rvalid_c%0d", c), rvalid, t4_rv[c-1]);
      if (c == 3) chk("t4_rdata_p0", rdata, 16'h5959);
      if (c == 5) chk("t4_rdata_p1", rdata, 16'h5D5D);
    end

    // Reset during the third beat of a locked read burst.
    do_reset();
    set_port(0, 9, 16'h0000); req = 3'b001; lock = 3'b001;
    tick(); tick(); tick();
    #1; rst_n = 1'b0; #1;
    chk("t5_rst_gnt", gnt, 0); chk("t5_rst_rvalid", rvalid, 0); chk("t5_rst_ram_en", ram_en, 0);
    tick(); #1; chk("t5_hold1_rvalid", rvalid, 0);
    tick(); #1; chk("t5_hold2_rvalid", rvalid, 0);
    rst_n = 1'b1; req = 3'b011; lock = '0; set_port(1, 8, 16'h0000);
    #1; chk("t5_post_idle_gnt", gnt, 0);
    tick(); #1; chk("t5_first_gnt", gnt, 1);
    req = '0;
    tick(); tick(); tick(); tick();

    // Ports 1 and 2 contend; outcome depends on the arbitration build.
    do_reset();
    set_port(1, 11, 16'h1111); set_port(2, 12, 16'h2222); req = 3'b110; we = 3'b110;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 4) req = 3'b100;
      #1;
      chk($sformatf("t6_gnt_c%0d", c), gnt, t6_g[c-1]);
    end
    req = '0; we = '0;
    tick(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
